// File: rtl/stage_writeback_pipe.sv
// Vector writeback stage: lane-masked data memory, writeback source select, read pipeline and post-reset clear.
// Optional build macro WB_BOUNDS_CHECK_EN enables out-of-range address detection (addrError).
module stage_writeback_pipe #(
  parameter int vecSize      = 4,
  parameter int registerSize = 8,
  parameter int memDepth     = 16,
  parameter int readLatency  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inValid,
  input  logic                             stall,
  output logic                             ready,
  input  logic                             writeEnable,
  input  logic [vecSize-1:0]               laneMask,
  input  logic [1:0]                       writeRegFrom,
  input  logic [registerSize-1:0]          address,
  input  logic [registerSize-1:0]          imm,
  input  logic [vecSize*registerSize-1:0]  writeData,
  input  logic [vecSize*registerSize-1:0]  aluResult,
  output logic                             outValid,
  output logic [vecSize*registerSize-1:0]  writeBackData,
  output logic                             addrError
);

  localparam int AW = (memDepth > 1) ? $clog2(memDepth) : 1;

  typedef logic [vecSize-1:0][registerSize-1:0] vec_t;
  typedef enum logic {CLEAR, RUN} state_t;

  if (readLatency < 1 || readLatency > 4) begin : g_bad_latency
    $error("readLatency must be in 1..4");
  end
`ifndef WB_BOUNDS_CHECK_EN
  if ((1 << AW) != memDepth) begin : g_bad_depth
    $error("memDepth must be a power of two without bounds checking");
  end
`endif

  state_t          state, state_next;
  logic [AW-1:0]   clr_cnt;
  logic            clr_last;
  logic            clearing;
  logic            accept;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            unused_addr;
  vec_t            wdata, alu, rd_merged, rd_val, sel;
  vec_t            mem [memDepth];
  vec_t            pipe_data [readLatency];
  logic [readLatency-1:0] pipe_valid, pipe_err;

  assign wdata       = writeData;
  assign alu         = aluResult;
  assign idx         = address[AW-1:0];
  assign unused_addr = ^address;
  assign clr_last    = (clr_cnt == AW'(memDepth - 1));
  assign accept      = inValid & ready & ~stall;

`ifdef WB_BOUNDS_CHECK_EN
  assign in_range = (int'(address) < memDepth);
`else
  // Upper address bits are ignored, so every access wraps into the memory.
  assign in_range = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset)         clr_cnt <= '0;
    else if (clearing) clr_cnt <= clr_cnt + 1'b1;
  end

  // Next-state logic
  always_comb begin
    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    state_next = state;
    case (state)
      CLEAR:   if (clr_last) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    ready    = 1'b0;
    clearing = 1'b0;
    case (state)
      CLEAR:   clearing = 1'b1;
      RUN:     ready    = 1'b1;
      default: clearing = 1'b0;
    endcase
  end

  // Write-first read: lanes being written this cycle return the new store data.
  always_comb begin
    rd_merged = mem[idx];
    if (writeEnable) begin
      for (int i = 0; i < vecSize; i++) begin
        if (laneMask[i]) rd_merged[i] = wdata[i];
      end
    end
    rd_val = in_range ? rd_merged : '0;
  end

  always_comb begin
    sel = '0;
    case (writeRegFrom)
      2'd0: sel = rd_val;
      2'd1: sel = alu;
      2'd2: for (int i = 0; i < vecSize; i++) sel[i] = imm;
      default: sel = '0;
    endcase
  end

  // NOTE: the memory array has no reset; CLEAR zeroes it one entry per cycle so it can still map onto RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearing) begin
        mem[clr_cnt] <= '0;
      end else if (accept && writeEnable && in_range) begin
        for (int i = 0; i < vecSize; i++) begin
          if (laneMask[i]) mem[idx][i] <= wdata[i];
        end
      end
    end
  end

  // Read pipeline: data only advances behind a valid bit, so outputs hold between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int k = 0; k < readLatency; k++) pipe_data[k] <= '0;
    end else if (!stall) begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept & ~in_range;
      if (accept) pipe_data[0] <= sel;
      for (int k = 1; k < readLatency; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_err[k]   <= pipe_err[k-1];
        if (pipe_valid[k-1]) pipe_data[k] <= pipe_data[k-1];
      end
    end
  end

  assign outValid      = pipe_valid[readLatency-1];
  assign writeBackData = pipe_data[readLatency-1];

`ifdef WB_BOUNDS_CHECK_EN
  assign addrError = pipe_err[readLatency-1];
`else
  assign addrError = 1'b0;
`endif

endmodule

// File: tb/tb_stage_writeback_pipe.sv
// Testbench for stage_writeback_pipe: directed scenarios then random traffic, compared every cycle
// against a transaction-level model (flat memory words plus a queue of pending results).
module tb_stage_writeback_pipe;

  localparam int VS  = 4;
  localparam int RS  = 8;
  localparam int LAT = 1;
`ifdef WB_BOUNDS_CHECK_EN
  localparam int MEM_DEPTH = 12;
  localparam int ADDR_MAX  = 15;
`else
  localparam int MEM_DEPTH = 16;
  localparam int ADDR_MAX  = 31;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          inValid, stall, ready, writeEnable;
  logic [VS-1:0] laneMask;
  logic [1:0]    writeRegFrom;
  logic [RS-1:0] address, imm;
  logic [31:0]   writeData, aluResult, writeBackData;
  logic          outValid, addrError;

  always #5 clk = ~clk;

  stage_writeback_pipe #(
    .vecSize(VS), .registerSize(RS), .memDepth(MEM_DEPTH), .readLatency(LAT)
  ) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .stall(stall), .ready(ready),
    .writeEnable(writeEnable), .laneMask(laneMask), .writeRegFrom(writeRegFrom),
    .address(address), .imm(imm), .writeData(writeData), .aluResult(aluResult),
    .outValid(outValid), .writeBackData(writeBackData), .addrError(addrError)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          age;
  } pend_t;

  logic [31:0] ref_mem [MEM_DEPTH];
  pend_t       pend_q [$];
  int          clr_left  = MEM_DEPTH;
  logic        exp_valid = 1'b0;
  logic        exp_err   = 1'b0;
  logic        exp_ready = 1'b0;
  logic [31:0] exp_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < VS; i++) r[i*RS +: RS] = m[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Applies one clock edge to the model using the inputs the bench is driving.
  task automatic model_edge();
    logic        acc, oob;
    logic [31:0] m, merged, val;
    int          idx;
    pend_t       e;
    if (reset) begin
      clr_left = MEM_DEPTH;
      pend_q.delete();
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_data  = '0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      acc = inValid && exp_ready && !stall;
      if (acc) begin
`ifdef WB_BOUNDS_CHECK_EN
        oob = (int'(address) >= MEM_DEPTH);
`else
        oob = 1'b0;
`endif
        idx    = int'(address) % MEM_DEPTH;
        m      = byte_mask(laneMask);
        merged = oob ? 32'h0 : ref_mem[idx];
        if (writeEnable && !oob) begin
          merged = (merged & ~m) | (writeData & m);
          ref_mem[idx] = merged;
        end
        case (writeRegFrom)
          2'd0:    val = merged;
          2'd1:    val = aluResult;
          2'd2:    val = {4{imm}};
          default: val = 32'h0;
        endcase
        pend_q.push_back('{data: val, err: oob, age: 0});
      end
      if (!stall) begin
        foreach (pend_q[i]) pend_q[i].age++;
        if (pend_q.size() > 0 && pend_q[0].age >= LAT) begin
          e = pend_q.pop_front();
          exp_valid = 1'b1;
          exp_data  = e.data;
          exp_err   = e.err;
        end else begin
          exp_valid = 1'b0;
          exp_err   = 1'b0;
        end
      end
      if (clr_left > 0) clr_left--;
    end
    exp_ready = (clr_left == 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check($sformatf("outValid@%0d", cyc), outValid, exp_valid);
    check($sformatf("data@%0d", cyc), writeBackData, exp_data);
    check($sformatf("ready@%0d", cyc), ready, exp_ready);
    check($sformatf("addrError@%0d", cyc), addrError, exp_err);
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] m, input logic [1:0] src,
                       input logic [7:0] a, input logic [7:0] im, input logic [31:0] wd,
                       input logic [31:0] alu);
    inValid = v; writeEnable = we; laneMask = m; writeRegFrom = src;
    address = a; imm = im; writeData = wd; aluResult = alu;
  endtask

  task automatic op(input logic we, input logic [3:0] m, input logic [1:0] src, input logic [7:0] a,
                    input logic [7:0] im, input logic [31:0] wd, input logic [31:0] alu);
    drive(1'b1, we, m, src, a, im, wd, alu);
    cycle();
    drive(1'b0, 1'b0, 4'h0, 2'd0, 8'h0, 8'h0, 32'h0, 32'h0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    check(tag, n, MEM_DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 2'd0, 8'h0, 8'h0, 32'h0, 32'h0);

    // Post-reset clear
    cycle();
    cycle();
    reset = 1'b0;
    wait_ready("clear_len");
    op(1'b0, 4'h0, 2'd0, 8'd0, 8'h0, 32'h0, 32'h0);
    check("read0_valid", outValid, 1'b1);
    check("read0_data", writeBackData, 32'h0000_0000);
    cycle();
    check("read0_pulse", outValid, 1'b0);

    // Masked writes
    op(1'b1, 4'b1111, 2'd3, 8'd4, 8'h0, 32'hDEAD_BEEF, 32'h0);
    op(1'b1, 4'b0101, 2'd3, 8'd4, 8'h0, 32'h1122_3344, 32'h0);
    op(1'b0, 4'b0000, 2'd0, 8'd4, 8'h0, 32'h0, 32'h0);
    check("masked_read", writeBackData, 32'hDE22_BE44);

    // Source select
    op(1'b0, 4'h0, 2'd2, 8'd4, 8'hFE, 32'h0, 32'h0);
    check("src_imm", writeBackData, 32'hFEFE_FEFE);
    op(1'b0, 4'h0, 2'd1, 8'd4, 8'h0, 32'h0, 32'hCAFE_BABE);
    check("src_alu", writeBackData, 32'hCAFE_BABE);
    op(1'b0, 4'h0, 2'd3, 8'd4, 8'h0, 32'h0, 32'h0);
    check("src_zero", writeBackData, 32'h0000_0000);

    // Same-cycle write and read, then back-to-back issue
    op(1'b1, 4'hF, 2'd0, 8'd7, 8'h0, 32'hA5A5_A5A5, 32'h0);
    check("write_first", writeBackData, 32'hA5A5_A5A5);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 4'h0, 2'd2, 8'd0, 8'(i), 32'h0, 32'h0);
      cycle();
      check($sformatf("b2b_valid%0d", i), outValid, 1'b1);
      check($sformatf("b2b_data%0d", i), writeBackData, {4{8'(i)}});
    end
    drive(1'b0, 1'b0, 4'h0, 2'd0, 8'h0, 8'h0, 32'h0, 32'h0);
    cycle();

    // Stall freezes outputs and blocks the write presented meanwhile
    op(1'b0, 4'h0, 2'd2, 8'd0, 8'h77, 32'h0, 32'h0);
    stall = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 2'd0, 8'd9, 8'h0, 32'h1234_5678, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("stall_valid%0d", i), outValid, 1'b1);
      check($sformatf("stall_data%0d", i), writeBackData, 32'h7777_7777);
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 2'd0, 8'h0, 8'h0, 32'h0, 32'h0);
    cycle();
    check("stall_release", outValid, 1'b0);
    op(1'b0, 4'h0, 2'd0, 8'd9, 8'h0, 32'h0, 32'h0);
    check("stall_no_write", writeBackData, 32'h0000_0000);

`ifdef WB_BOUNDS_CHECK_EN
    // Out-of-range accesses
    op(1'b1, 4'hF, 2'd3, 8'd13, 8'h0, 32'hFFFF_FFFF, 32'h0);
    check("oob_write_err", addrError, 1'b1);
    op(1'b0, 4'h0, 2'd0, 8'd13, 8'h0, 32'h0, 32'h0);
    check("oob_read_data", writeBackData, 32'h0000_0000);
    check("oob_read_err", addrError, 1'b1);
    op(1'b0, 4'h0, 2'd0, 8'd1, 8'h0, 32'h0, 32'h0);
    check("oob_no_alias", writeBackData, 32'h0000_0000);
    op(1'b0, 4'h0, 2'd0, 8'd4, 8'h0, 32'h0, 32'h0);
    check("oob_entry4", writeBackData, 32'hDE22_BE44);
`else
    // Address aliasing
    op(1'b1, 4'hF, 2'd3, 8'h14, 8'h0, 32'h0BAD_F00D, 32'h0);
    op(1'b0, 4'h0, 2'd0, 8'd4, 8'h0, 32'h0, 32'h0);
    check("alias_read", writeBackData, 32'h0BAD_F00D);
    check("alias_err", addrError, 1'b0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 2'($urandom),
            8'($urandom_range(0, ADDR_MAX)), 8'($urandom), $urandom, $urandom);
      cycle();
    end

    // Reset in the middle of traffic
    stall = 1'b0;
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 2'd1, 8'd4, 8'h0, 32'h5555_AAAA, 32'h1234_5678);
    cycle();
    check("reset_outValid", outValid, 1'b0);
    check("reset_data", writeBackData, 32'h0000_0000);
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 2'd0, 8'h0, 8'h0, 32'h0, 32'h0);
    wait_ready("reclear_len");
    op(1'b0, 4'h0, 2'd0, 8'd4, 8'h0, 32'h0, 32'h0);
    check("post_reset_read", writeBackData, 32'h0000_0000);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
